// File: rtl/bsg_mac_accum_pkg.sv
// Shared types and sizing helpers for bsg_mac_accum and its element counter.
package bsg_mac_accum_pkg;

    typedef enum logic {
        e_ACCUM = 1'b0,
        e_DONE  = 1'b1
    } bsg_mac_accum_state_e;

    // Counter width that stays legal when only one value is needed.
    function automatic int safe_clog2_f(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Sized so that els_p full-width products plus the shifted bias cannot overflow.
    function automatic int acc_width_f(input int width_p, input int els_p);
        return 2 * width_p + $clog2(els_p + 1);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up in one cycle yields init_val_p + 1.
module bsg_counter_clear_up
    import bsg_mac_accum_pkg::*;
#(
    parameter int max_val_p  = 3,
    parameter int init_val_p = 0,
    localparam int width_lp  = safe_clog2_f(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_o <= width_lp'(init_val_p);
        else
            count_o <= (clear_i ? width_lp'(init_val_p) : count_o) + width_lp'(up_i);
    end

endmodule

// File: rtl/bsg_mac_accum.sv
// Fixed-point dot product + bias, rescaled and saturated for the activation stage.
// Optional macro BSG_MAC_ACCUM_PIPE_MULT_EN registers the product before accumulation.
module bsg_mac_accum
    import bsg_mac_accum_pkg::*;
#(
    parameter int width_p     = 20,
    parameter int frac_p      = 16,
    parameter int els_p       = 4,
    parameter int ang_width_p = 21
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    input  logic [width_p-1:0]     weight_i,
    input  logic [width_p-1:0]     bias_i,
    input  logic                   tanh_sel_i,
    output logic                   v_o,
    input  logic                   ready_i,
    output logic [ang_width_p-1:0] sum_o,
    output logic                   tanh_sel_o,
    output logic                   overflow_o
);

    localparam int acc_w_lp  = acc_width_f(width_p, els_p);
    localparam int prod_w_lp = 2 * width_p;
    localparam int cnt_w_lp  = safe_clog2_f(els_p);

    localparam logic signed [acc_w_lp-1:0] sat_max_lp =
        {{(acc_w_lp - ang_width_p + 1){1'b0}}, {(ang_width_p - 1){1'b1}}};
    localparam logic signed [acc_w_lp-1:0] sat_min_lp = ~sat_max_lp;

    bsg_mac_accum_state_e state_r, state_n;

    logic                 accept, first, last;
    logic [cnt_w_lp-1:0]  count;

    logic signed [prod_w_lp-1:0] prod;
    logic                        m_v, m_first, m_last;
    logic signed [prod_w_lp-1:0] m_prod;
    logic        [width_p-1:0]   m_bias;

    logic signed [acc_w_lp-1:0] acc_r, acc_next, prod_ext, bias_ext, shifted;
    logic [ang_width_p-1:0]     sat_sum;
    logic                       sat_ovf;

    assign accept = v_i & ready_o;
    assign first  = (count == '0);
    assign last   = (count == cnt_w_lp'(els_p - 1));

    // The last accept clears instead of counting so the count lands on 0.
    bsg_counter_clear_up #(
        .max_val_p (els_p - 1),
        .init_val_p(0)
    ) elem_cnt (
        .clk_i  (clk_i),
        .reset_i(~reset_n_i),
        .clear_i(accept & last),
        .up_i   (accept & ~last),
        .count_o(count)
    );

    assign prod = $signed(data_i) * $signed(weight_i);

`ifdef BSG_MAC_ACCUM_PIPE_MULT_EN
    logic                        m_v_r, m_first_r, m_last_r;
    logic signed [prod_w_lp-1:0] m_prod_r;
    logic        [width_p-1:0]   m_bias_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            m_v_r     <= 1'b0;
            m_first_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_prod_r  <= '0;
            m_bias_r  <= '0;
        end else begin
            m_v_r     <= accept;
            m_first_r <= first;
            m_last_r  <= last;
            m_prod_r  <= prod;
            m_bias_r  <= bias_i;
        end
    end

    assign m_v     = m_v_r;
    assign m_first = m_first_r;
    assign m_last  = m_last_r;
    assign m_prod  = m_prod_r;
    assign m_bias  = m_bias_r;
    // Stall while the final product is still in flight.
    assign ready_o = (state_r == e_ACCUM) & ~(m_v_r & m_last_r);
`else
    assign m_v     = accept;
    assign m_first = first;
    assign m_last  = last;
    assign m_prod  = prod;
    assign m_bias  = bias_i;
    assign ready_o = (state_r == e_ACCUM);
`endif

    assign v_o = (state_r == e_DONE);

    assign prod_ext = {{(acc_w_lp - prod_w_lp){m_prod[prod_w_lp-1]}}, m_prod};
    assign bias_ext = {{(acc_w_lp - width_p){m_bias[width_p-1]}}, m_bias} <<< frac_p;
    assign acc_next = (m_first ? bias_ext : acc_r) + prod_ext;
    assign shifted  = acc_next >>> frac_p;

    always_comb begin
        sat_sum = shifted[ang_width_p-1:0];
        sat_ovf = 1'b0;
        if (shifted > sat_max_lp) begin
            sat_sum = sat_max_lp[ang_width_p-1:0];
            sat_ovf = 1'b1;
        end else if (shifted < sat_min_lp) begin
            sat_sum = sat_min_lp[ang_width_p-1:0];
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            state_r <= e_ACCUM;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ACCUM: if (m_v & m_last) state_n = e_DONE;
            e_DONE:  if (ready_i)      state_n = e_ACCUM;
            default: state_n = e_ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            acc_r      <= '0;
            sum_o      <= '0;
            tanh_sel_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (accept & first)
                tanh_sel_o <= tanh_sel_i;
            if (m_v)
                acc_r <= acc_next;
            if (m_v & m_last) begin
                sum_o      <= sat_sum;
                overflow_o <= sat_ovf;
            end
            if ((state_r == e_DONE) & ready_i)
                acc_r <= '0;
        end
    end

endmodule

// File: tb/tb_bsg_mac_accum.sv
// Directed-vector bench for bsg_mac_accum; honours BSG_MAC_ACCUM_PIPE_MULT_EN for timing.
module tb_bsg_mac_accum;

    localparam int width_p     = 20;
    localparam int frac_p      = 16;
    localparam int els_p       = 4;
    localparam int ang_width_p = 21;
`ifdef BSG_MAC_ACCUM_PIPE_MULT_EN
    localparam int lat_lp = 2;
`else
    localparam int lat_lp = 1;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n_i, v_i, ready_i, tanh_sel_i;
    logic [width_p-1:0]     data_i, weight_i, bias_i;
    logic                   ready_o, v_o, tanh_sel_o, overflow_o;
    logic [ang_width_p-1:0] sum_o;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned cyc    = 0;

    bsg_mac_accum #(
        .width_p    (width_p),
        .frac_p     (frac_p),
        .els_p      (els_p),
        .ang_width_p(ang_width_p)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .weight_i  (weight_i),
        .bias_i    (bias_i),
        .tanh_sel_i(tanh_sel_i),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .sum_o     (sum_o),
        .tanh_sel_o(tanh_sel_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [19:0] d, input logic [19:0] w,
                             input logic [19:0] b, input logic t);
        int n;
        v_i        = 1'b1;
        data_i     = d;
        weight_i   = w;
        bias_i     = b;
        tanh_sel_i = t;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_val("ready_timeout", 64'(ready_o), 64'd1);
        tick();
    endtask

    // Later elements carry junk bias/tanh_sel to show only element 0 is sampled.
    task automatic send_vector(input logic [19:0] d, input logic [19:0] w,
                               input logic [19:0] b, input logic t);
        for (int i = 0; i < els_p; i++) begin
            if (i == 0) send_elem(d, w, b, t);
            else        send_elem(d, w, 20'h55555, ~t);
        end
        v_i = 1'b0;
    endtask

    task automatic wait_vo(output int n);
        n = 0;
        while (!v_o && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_val("vo_timeout", 64'(v_o), 64'd1);
    endtask

    task automatic ack();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_val("ack_vo_low", 64'(v_o), 64'd0);
    endtask

    initial begin
        int n;
        int unsigned t0, t1, t2;
        logic [19:0] junk;

        reset_n_i  = 1'b0;
        v_i        = 1'b0;
        ready_i    = 1'b0;
        data_i     = '0;
        weight_i   = '0;
        bias_i     = '0;
        tanh_sel_i = 1'b0;
        repeat (3) tick();
        reset_n_i = 1'b1;
        check_val("rst_v_o",     64'(v_o),        64'd0);
        check_val("rst_ready_o", 64'(ready_o),    64'd1);
        check_val("rst_sum_o",   64'(sum_o),      64'd0);
        check_val("rst_tanh",    64'(tanh_sel_o), 64'd0);
        check_val("rst_ovf",     64'(overflow_o), 64'd0);

        // Nominal: 4 x (1.0 * 0.5) = 2.0
        send_vector(20'h10000, 20'h08000, 20'h00000, 1'b1);
        wait_vo(n);
        check_val("nom_latency", 64'(n),          64'(lat_lp - 1));
        check_val("nom_v_o",     64'(v_o),        64'd1);
        check_val("nom_ready_o", 64'(ready_o),    64'd0);
        check_val("nom_sum",     64'(sum_o),      64'h20000);
        check_val("nom_ovf",     64'(overflow_o), 64'd0);
        check_val("nom_tanh",    64'(tanh_sel_o), 64'd1);
        ack();

        // Negative: 4 x (-1.0 * 3.0) = -12.0
        send_vector(20'hF0000, 20'h30000, 20'h00000, 1'b0);
        wait_vo(n);
        check_val("neg_sum",  64'(sum_o),      64'h140000);
        check_val("neg_ovf",  64'(overflow_o), 64'd0);
        check_val("neg_tanh", 64'(tanh_sel_o), 64'd0);
        ack();

        // Positive saturation: 4 x 49 + 1 = 197
        send_vector(20'h70000, 20'h70000, 20'h10000, 1'b1);
        wait_vo(n);
        check_val("satp_sum", 64'(sum_o),      64'h0FFFFF);
        check_val("satp_ovf", 64'(overflow_o), 64'd1);
        ack();

        // Negative saturation: 4 x -49 + 1 = -195
        send_vector(20'h70000, 20'h90000, 20'h10000, 1'b0);
        wait_vo(n);
        check_val("satn_sum", 64'(sum_o),      64'h100000);
        check_val("satn_ovf", 64'(overflow_o), 64'd1);
        ack();

        // Backpressure with upstream pushing junk pairs throughout
        send_vector(20'h10000, 20'h08000, 20'h00000, 1'b1);
        wait_vo(n);
        junk       = 20'h7FFFF;
        v_i        = 1'b1;
        data_i     = junk;
        weight_i   = junk;
        bias_i     = junk;
        tanh_sel_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_sum",   64'(sum_o),   64'h20000);
            check_val("bp_ready", 64'(ready_o), 64'd0);
            check_val("bp_v_o",   64'(v_o),     64'd1);
            tick();
        end
        check_val("bp_tanh_hold", 64'(tanh_sel_o), 64'd1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        v_i     = 1'b0;
        send_vector(20'hF0000, 20'h30000, 20'h00000, 1'b0);
        wait_vo(n);
        check_val("bp_next_sum", 64'(sum_o), 64'h140000);
        ack();

        // Reset mid-vector, then 4 x 1.0 + 0.5 = 4.5
        send_elem(20'h10000, 20'h08000, 20'h00000, 1'b1);
        send_elem(20'h10000, 20'h08000, 20'h55555, 1'b0);
        v_i       = 1'b0;
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        check_val("mid_rst_ready", 64'(ready_o), 64'd1);
        check_val("mid_rst_v_o",   64'(v_o),     64'd0);
        send_vector(20'h10000, 20'h10000, 20'h08000, 1'b0);
        wait_vo(n);
        check_val("mid_rst_sum", 64'(sum_o),      64'h48000);
        check_val("mid_rst_ovf", 64'(overflow_o), 64'd0);
        ack();

        // Back-to-back with ready_i tied high
        ready_i = 1'b1;
        send_vector(20'h10000, 20'h08000, 20'h00000, 1'b1);
        t0 = cyc;
        wait_vo(n);
        check_val("b2b_sum0", 64'(sum_o), 64'h20000);
        send_vector(20'hF0000, 20'h30000, 20'h00000, 1'b0);
        t1 = cyc;
        wait_vo(n);
        check_val("b2b_sum1", 64'(sum_o), 64'h140000);
        send_vector(20'h10000, 20'h10000, 20'h08000, 1'b1);
        t2 = cyc;
        wait_vo(n);
        check_val("b2b_sum2", 64'(sum_o), 64'h48000);
        check_val("b2b_period1", 64'(t1 - t0), 64'(els_p + lat_lp));
        check_val("b2b_period2", 64'(t2 - t1), 64'(els_p + lat_lp));
        tick();
        check_val("b2b_drain_v_o", 64'(v_o), 64'd0);
        ready_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
